// File: rtl/top_for_single.sv
// Single-cycle MIPS-subset core: instruction arrives on a port; PC, register file,
// ALU, decode and a word-addressed data memory all live here.
module top_for_single #(
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [31:0] PC,
  output logic [31:0] addr,
  output logic [31:0] digit
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  logic        [DATA_W-1:0] rf   [32];
  logic        [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic        [DATA_W-1:0] pc_q;

  logic        [5:0]        opcode;
  logic        [4:0]        rs;
  logic        [4:0]        rt;
  logic        [4:0]        rd;
  logic        [5:0]        funct;
  logic        [15:0]       imm;
  logic        [25:0]       target;

  logic signed [DATA_W-1:0] rs_val;
  logic signed [DATA_W-1:0] rt_val;
  logic signed [DATA_W-1:0] imm_sext;
  logic signed [DATA_W-1:0] alu_b;
  logic        [DATA_W-1:0] alu_res;
  logic        [DATA_W-1:0] mem_rdata;
  logic        [AW-1:0]     mem_idx;

  alu_op_e                  alu_op;
  logic                     use_imm;
  logic                     reg_we;
  logic        [4:0]        reg_wa;
  logic                     mem_we;
  logic                     mem_rd;
  logic                     is_beq;
  logic                     is_j;

  logic        [DATA_W-1:0] pc_plus4;
  logic        [DATA_W-1:0] pc_next;
  logic        [DATA_W-1:0] wb_val;

  // Wrapping 32-bit arithmetic; slt compares as signed and yields 0/1.
  function automatic logic [DATA_W-1:0] alu_calc(
    input alu_op_e                  op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    case (op)
      ALU_ADD: r = DATA_W'(a + b);
      ALU_SUB: r = DATA_W'(a - b);
      ALU_AND: r = DATA_W'(a & b);
      ALU_OR:  r = DATA_W'(a | b);
      ALU_SLT: r = (a < b) ? DATA_W'(1) : '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign target = instruction[25:0];

  assign imm_sext = {{16{imm[15]}}, imm};
  assign rs_val   = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : rf[rt];

  always_comb begin
    alu_op  = ALU_ZERO;
    use_imm = 1'b0;
    reg_we  = 1'b0;
    reg_wa  = 5'd0;
    mem_we  = 1'b0;
    mem_rd  = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_wa = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        reg_we  = 1'b1;
        reg_wa  = rt;
      end
      OP_LW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        reg_we  = 1'b1;
        reg_wa  = rt;
        mem_rd  = 1'b1;
      end
      OP_SW: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  assign alu_b     = use_imm ? imm_sext : rt_val;
  assign alu_res   = alu_calc(alu_op, rs_val, alu_b);
  // Word index drops the byte offset; upper address bits alias back into the array.
  assign mem_idx   = alu_res[AW+1:2];
  assign mem_rdata = dmem[mem_idx];
  assign wb_val    = mem_rd ? mem_rdata : alu_res;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_next  = pc_plus4;
    if (is_j)
      pc_next = {pc_plus4[31:28], target, 2'b00};
    else if (is_beq && (alu_res == '0))
      pc_next = pc_plus4 + DATA_W'(imm_sext <<< 2);
  end

  // Commit edge: PC, register write and memory write land together.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= DATA_W'(i);
    end else if (reg_we && (reg_wa != 5'd0)) begin
      rf[reg_wa] <= wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_idx] <= rt_val;
    end
  end

  assign PC    = pc_q;
  assign addr  = alu_res;
  assign digit = wb_val;

endmodule

// File: tb/tb_top_for_single.sv
// Directed bench for top_for_single: each step drives one instruction, checks the
// combinational outputs against hand-computed values, then commits it with a clock edge.
module tb_top_for_single;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic [31:0] addr;
  logic [31:0] digit;

  int checks;
  int errors;

  top_for_single #(
    .DMEM_DEPTH(64),
    .RESET_PC  (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .PC         (PC),
    .addr       (addr),
    .digit      (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive an instruction, verify PC/addr/digit before the edge, then commit it.
  task automatic exec(input string tag, input logic [31:0] ins, input logic [31:0] exp_pc,
                      input logic [31:0] exp_addr, input logic [31:0] exp_digit);
    instruction = ins;
    #1;
    check({tag, ".pc"},    PC,    exp_pc);
    check({tag, ".addr"},  addr,  exp_addr);
    check({tag, ".digit"}, digit, exp_digit);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    instruction = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset.pc", PC, 32'h0);

    // add $16,$17,$18 four times
    exec("add0", 32'h02328020, 32'h00, 32'h23, 32'h23);
    exec("add1", 32'h02328020, 32'h04, 32'h23, 32'h23);
    exec("add2", 32'h02328020, 32'h08, 32'h23, 32'h23);
    exec("add3", 32'h02328020, 32'h0C, 32'h23, 32'h23);
    // sub $9,$18,$17
    exec("sub",  32'h02514822, 32'h10, 32'h01, 32'h01);
    // sw $16,4($0) then lw $8,4($0)
    exec("sw",   32'hAC100004, 32'h14, 32'h04, 32'h04);
    exec("lw",   32'h8C080004, 32'h18, 32'h04, 32'h23);
    // add $16,$8,$0 shows lw wrote $8; add $16,$9,$0 shows sub wrote $9
    exec("rd8",  32'h01008020, 32'h1C, 32'h23, 32'h23);
    exec("rd9",  32'h01208020, 32'h20, 32'h01, 32'h01);
    // beq $0,$0,2 taken from 0x24 -> 0x30
    exec("beqT", 32'h10000002, 32'h24, 32'h00, 32'h00);
    // j 0x40
    exec("j",    32'h08000010, 32'h30, 32'h00, 32'h00);
    // beq $1,$2,2 not taken: digit = 1-2
    exec("beqN", 32'h10220002, 32'h40, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // addi $0,$0,0 and unknown opcode behave as NOPs
    exec("addi0", 32'h20000000, 32'h44, 32'h00, 32'h00);
    exec("unkop", 32'hFC000000, 32'h48, 32'h00, 32'h00);
    // add $0,$17,$18: value shown but discarded
    exec("add0w", 32'h02320020, 32'h4C, 32'h23, 32'h23);
    // add $16,$0,$0 reads $0 as zero
    exec("rd0",   32'h00008020, 32'h50, 32'h00, 32'h00);
    // addi $5,$0,-1 then slt $6,$5,$1 (signed: -1 < 1)
    exec("addiN", 32'h2005FFFF, 32'h54, 32'hFFFFFFFF, 32'hFFFFFFFF);
    exec("slt",   32'h00A1302A, 32'h58, 32'h01, 32'h01);
    // or $7,$12,$3
    exec("or",    32'h01833825, 32'h5C, 32'h0F, 32'h0F);
    // unknown funct is a NOP
    exec("unkfn", 32'h0232803F, 32'h60, 32'h00, 32'h00);
    // and $7,$5,$3 with $5 = -1
    exec("and",   32'h00A33824, 32'h64, 32'h03, 32'h03);

    // Reset mid-run with a store pending: the store must not land
    rst         = 1'b1;
    instruction = 32'hAC110008;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst2.pc", PC, 32'h0);
    // $5 restored to 5, dmem cleared, add restored
    exec("r_rd5", 32'h00A08020, 32'h00, 32'h05, 32'h05);
    exec("r_lw4", 32'h8C080004, 32'h04, 32'h04, 32'h00);
    exec("r_lw8", 32'h8C080008, 32'h08, 32'h08, 32'h00);
    exec("r_add", 32'h02328020, 32'h0C, 32'h23, 32'h23);
    check("final.pc", PC, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
